fakeregfile_64x64_ctrl: RTL
===========================

# fakeregfile_64x64_ctrl

Initiator-side controller for the 64x64 fake register file macro. It accepts read and write requests from a client over a valid/ready port and drives the macro's `ce`/`we`/`addr`/`wd` pins from registers, so the macro never sees X or glitches. It captures the macro's registered read data at the one valid cycle and returns it through a response FIFO with valid/ready backpressure. It sits between client logic and the macro instance, one controller per macro.

## Interface
- `BITS`, 64, data width; equals the macro word width.
- `WORD_DEPTH`, 64, macro depth.
- `ADDR_WIDTH`, 6, address width; `2**ADDR_WIDTH == WORD_DEPTH`.
- `RSP_DEPTH`, 4, response FIFO entries; minimum 3, power of two.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `req_valid_in`  in  1  client request valid.
- `req_ready_out`  out  1  controller can accept a request.
- `req_we_in`  in  1  1 = write, 0 = read.
- `req_addr_in`  in  ADDR_WIDTH  request address.
- `req_wd_in`  in  BITS  write data.
- `rsp_valid_out`  out  1  response available (FIFO head).
- `rsp_ready_in`  in  1  client takes the response.
- `rsp_rd_out`  out  BITS  macro read data for the operation.
- `rsp_we_out`  out  1  echo of `req_we_in` for the operation.
- `mem_ce_out`  out  1  to macro `ce_in`; registered.
- `mem_we_out`  out  1  to macro `we_in`; registered.
- `mem_addr_out`  out  ADDR_WIDTH  to macro `addr_in`; registered.
- `mem_wd_out`  out  BITS  to macro `wd_in`; registered.
- `mem_rd_in`  in  BITS  from macro `rd_out`.

## Operation
- **Accept.** A request is accepted on a rising edge when `req_valid_in && req_ready_out`.
- **Outstanding count.** `outstanding` (width clog2(RSP_DEPTH)+1) is incremented on accept and decremented on pop (`rsp_valid_out && rsp_ready_in`). It holds when both happen on the same edge.
- **Ready.** `req_ready_out = (outstanding < RSP_DEPTH)` and depends on no other input. The FIFO can never overflow; there is no overflow path.
- **Issue stage.** On accept, the controller registers `mem_ce_out=1`, `mem_we_out=req_we_in`, `mem_addr_out=req_addr_in`, `mem_wd_out=req_wd_in`.
- **Idle issue.** With no accept, `mem_ce_out=0` and `mem_we_out=0`. `mem_addr_out` and `mem_wd_out` hold their last value and are never X.
- **Capture.** A 2-bit valid/we shift pipe tracks issued ops. The op issued at edge N is sampled by the macro at edge N+1. The controller pushes `{mem_rd_in, we}` into the FIFO at edge N+2. `mem_rd_in` is sampled only at that edge; it is X whenever the macro saw `ce=0`.
- **Write responses.** `rsp_rd_out` carries the pre-write contents of the word, because the macro reads the old word on a write cycle.
- **Write semantics.** The macro merges writes as `new = wd | old`. The controller does not compensate; clients and benches must account for this.
- **FIFO.** The response FIFO is in-order, with head on `rsp_*`. Push and pop on the same edge are allowed at any occupancy, including empty-with-push (no bypass: data appears the next cycle) and full.

## Timing
- **Reset values** (async, immediate on `rst_n_in` low):
  - `req_ready_out=1` (once released), `rsp_valid_out=0`, `rsp_rd_out=0`, `rsp_we_out=0`.
  - `mem_ce_out=0`, `mem_we_out=0`, `mem_addr_out=0`, `mem_wd_out=0`.
  - `outstanding=0`, pipe and FIFO cleared.
- **Reset mid-operation.** In-flight ops and queued responses are discarded with no response. `mem_ce_out` drops asynchronously. The macro contents are not reset.
- **Latency.** Accept at edge N gives `rsp_valid_out` high after edge N+2, when the FIFO was empty.
- **Throughput.** Back-to-back: one op per cycle sustained while `rsp_ready_in=1`.
- **Backpressure.** After `RSP_DEPTH` accepts with no pops, `req_ready_out=0` the next cycle. It returns to 1 the cycle after the first pop.
- **Stability.** `rsp_*` stays stable while `rsp_valid_out && !rsp_ready_in`.
- **Same-address ordering.** Same-address write then read on consecutive cycles returns the merged data, since the macro applies ops in issue order.

## Test plan
- **Reset.** Assert `rst_n_in=0` mid-burst with 3 ops outstanding -> all outputs at reset values that cycle. After release, no stale responses; `outstanding=0`.
- **Write then read.** Backdoor-zero the macro, then write 0x0F to addr 5, write 0xF0 to addr 5, read addr 5 -> responses in order:
  - `rd=0x00, we=1`
  - `rd=0x0F, we=1`
  - `rd=0xFF, we=0`
- **Streaming.** Stream 64 back-to-back reads of addr 0..63 (macro preloaded with data = addr*3), `rsp_ready_in=1` -> 64 responses on consecutive cycles, first 2 cycles after the first accept, each `rd = addr*3`.
- **Backpressure.** Hold `rsp_ready_in=0` and offer 6 requests -> exactly 4 accepted and `req_ready_out=0`. Release -> 4 responses in order, then the remaining 2 accepted.
- **Idle safety.** Idle for 20 cycles after reset -> `mem_ce_out=0` throughout, `mem_addr_out`/`mem_we_out` never X, no macro corruption warning.
- **Same-edge events.** Simultaneous push and pop with the FIFO full, and with it empty -> `outstanding` unchanged; data order preserved.

Source files
------------

// File: rtl/fakeregfile_64x64_ctrl.sv
// -----------------------------------------------------------------------------
// fakeregfile_64x64_ctrl
//
// Initiator-side controller for one 64x64 fake register file macro. Client
// read/write requests arrive over a valid/ready port. They are registered onto
// the macro pins, so the macro only ever sees clean, flop-driven ce/we/addr/wd.
// The macro's registered read data is captured in the single cycle where it is
// valid. It is then returned in order through a small response FIFO that has
// valid/ready backpressure.
//
// Ports
//   clk            single clock, rising edge
//   rst_n_in       asynchronous active-low reset
//   req_valid_in   client request valid
//   req_ready_out  controller can take a request (outstanding < RSP_DEPTH)
//   req_we_in      1 = write, 0 = read
//   req_addr_in    request word address
//   req_wd_in      write data
//   rsp_valid_out  response FIFO head valid
//   rsp_ready_in   client consumes the head response
//   rsp_rd_out     macro read data for the operation (pre-write data on writes)
//   rsp_we_out     echo of the request's we bit
//   mem_ce_out     macro chip enable (registered)
//   mem_we_out     macro write enable (registered)
//   mem_addr_out   macro address (registered, holds when idle)
//   mem_wd_out     macro write data (registered, holds when idle)
//   mem_rd_in      macro read data, valid one cycle after the macro samples
// -----------------------------------------------------------------------------
module fakeregfile_64x64_ctrl #(
    parameter int BITS       = 64,
    parameter int WORD_DEPTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_we_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [BITS-1:0]       req_wd_in,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic [BITS-1:0]       rsp_rd_out,
    output logic                  rsp_we_out,
    output logic                  mem_ce_out,
    output logic                  mem_we_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [BITS-1:0]       mem_wd_out,
    input  logic [BITS-1:0]       mem_rd_in
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Keeps the issued address inside the macro depth. With the default
    // 2**ADDR_WIDTH == WORD_DEPTH configuration this mask is all ones.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(WORD_DEPTH - 1);

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic accept;
    logic pop;
    logic push;

    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;

    // Ready comes only from the registered outstanding count. Every accepted
    // op owns a FIFO slot from accept until pop, so the FIFO cannot overflow.
    assign req_ready_out = (outstanding_q < CNT_W'(RSP_DEPTH));
    assign accept        = req_valid_in && req_ready_out;
    assign pop           = rsp_valid_out && rsp_ready_in;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue stage: macro pins driven straight from flops
    // ------------------------------------------------------------------
    logic                  mem_ce_q;
    logic                  mem_ce_d;
    logic                  mem_we_q;
    logic                  mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [BITS-1:0]       mem_wd_q;
    logic [BITS-1:0]       mem_wd_d;

    always_comb begin
        mem_ce_d   = accept;
        mem_we_d   = accept && req_we_in;
        // addr/wd hold while idle so the pins never toggle without ce.
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        if (accept) begin
            mem_addr_d = req_addr_in & ADDR_MASK;
            mem_wd_d   = req_wd_in;
        end
    end

    assign mem_ce_out   = mem_ce_q;
    assign mem_we_out   = mem_we_q;
    assign mem_addr_out = mem_addr_q;
    assign mem_wd_out   = mem_wd_q;

    // ------------------------------------------------------------------
    // Capture pipe
    // An op issued at edge N is sampled by the macro at N+1. Its read data
    // is on mem_rd_in between N+1 and N+2. The pipe stage below marks the
    // cycle in which mem_rd_in belongs to a real op. It is the only cycle
    // in which mem_rd_in is looked at, because the macro drives X otherwise.
    // ------------------------------------------------------------------
    logic pipe_vld_q;
    logic pipe_vld_d;
    logic pipe_we_q;
    logic pipe_we_d;

    assign pipe_vld_d = mem_ce_q;
    assign pipe_we_d  = mem_we_q;
    assign push       = pipe_vld_q;

    // ------------------------------------------------------------------
    // Response FIFO
    // Small and flop-based, so it can be cleared on reset and the head can
    // be presented combinationally. A push into an empty FIFO becomes
    // visible the cycle after the push edge; there is no bypass path.
    // ------------------------------------------------------------------
    logic [BITS-1:0]      fifo_rd_q [RSP_DEPTH];
    logic [BITS-1:0]      fifo_rd_d [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_we_q;
    logic [RSP_DEPTH-1:0] fifo_we_d;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;

    for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
        logic wr_sel;
        assign wr_sel        = push && (wr_ptr_q == PTR_W'(gi));
        assign fifo_rd_d[gi] = wr_sel ? mem_rd_in : fifo_rd_q[gi];
        assign fifo_we_d[gi] = wr_sel ? pipe_we_q : fifo_we_q[gi];
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign rsp_valid_out = (count_q != '0);
    assign rsp_rd_out    = fifo_rd_q[rd_ptr_q];
    assign rsp_we_out    = fifo_we_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // State registers
    // The reset is asynchronous so that mem_ce_out drops as soon as
    // rst_n_in falls. In-flight ops and queued responses are discarded.
    // The macro contents are not touched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            outstanding_q <= '0;
            mem_ce_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wd_q      <= '0;
            pipe_vld_q    <= 1'b0;
            pipe_we_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fifo_we_q     <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_rd_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            mem_ce_q      <= mem_ce_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wd_q      <= mem_wd_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_we_q     <= pipe_we_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_we_q     <= fifo_we_d;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_rd_q[i] <= fifo_rd_d[i];
            end
        end
    end

endmodule
